user_grant_access_bank: RTL and testbench

Parametrised, access-controlled register bank; successor to the single-register user-grant block. A grant handshake opens a write session for a privileged user ID. Writes are accepted only from the session holder, and repeated failed grant attempts trigger a timed lockout. It sits between the bus-side user agent and security-sensitive configuration registers.

---
 rtl/user_grant_access_bank_pkg.sv | 17 +
 rtl/user_grant_access_bank_if.sv | 42 ++++
 rtl/user_grant_access_bank_grant_fsm.sv | 103 ++++++++++
 rtl/user_grant_access_bank.sv | 97 +++++++++
 tb/tb_user_grant_access_bank.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/user_grant_access_bank_pkg.sv
// rtl/user_grant_access_bank_pkg.sv - shared state type, default grant ID and counter sizing helper
package user_grant_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        LOCKOUT = 2'd2
    } ugab_state_e;

    localparam logic [2:0] DEFAULT_GRANT_ID = 3'b100;

    // Bits needed to hold every value 0..max_val, never less than one.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/user_grant_access_bank_if.sv
// rtl/user_grant_access_bank_if.sv - user-agent bus bundle; rd_err exists only with READ_PROTECT_EN
interface user_grant_access_bank_if #(
    parameter int DATA_W   = 8,
    parameter int USR_W    = 3,
    parameter int NUM_REGS = 4
);
    localparam int AW = $clog2(NUM_REGS);

    logic [USR_W-1:0]  usr_id;
    logic              grant_req;
    logic              grant_rel;
    logic              wr_en;
    logic              rd_en;
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              wr_ack;
    logic              wr_err;
    logic              granted;
    logic              locked;
`ifdef READ_PROTECT_EN
    logic              rd_err;
`endif

    modport master (
        output usr_id, grant_req, grant_rel, wr_en, rd_en, addr, data_in,
        input  data_out, rd_valid, wr_ack, wr_err, granted, locked
`ifdef READ_PROTECT_EN
        , input rd_err
`endif
    );

    modport slave (
        input  usr_id, grant_req, grant_rel, wr_en, rd_en, addr, data_in,
        output data_out, rd_valid, wr_ack, wr_err, granted, locked
`ifdef READ_PROTECT_EN
        , output rd_err
`endif
    );

endinterface

// File: rtl/user_grant_access_bank_grant_fsm.sv
// rtl/user_grant_access_bank_grant_fsm.sv - session FSM with fail, lockout and idle-timeout counters
module ugab_grant_fsm
    import user_grant_pkg::*;
#(
    parameter int               USR_W        = 3,
    parameter logic [USR_W-1:0] GRANT_ID     = USR_W'(DEFAULT_GRANT_ID),
    parameter int               MAX_FAIL     = 3,
    parameter int               LOCK_CYCLES  = 16,
    parameter int               SESS_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [USR_W-1:0] usr_id,
    input  logic             grant_req,
    input  logic             grant_rel,
    input  logic             access,
    output logic             granted,
    output logic             locked,
    output logic [USR_W-1:0] sess_id
);

    localparam int FW = cnt_w(MAX_FAIL);
    localparam int LW = cnt_w(LOCK_CYCLES);
    localparam int IW = cnt_w(SESS_TIMEOUT);

    localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAIL - 1);
    localparam logic [LW-1:0] LOCK_INIT = LW'(LOCK_CYCLES);
    localparam logic [IW-1:0] IDLE_LAST = IW'(SESS_TIMEOUT - 1);

    ugab_state_e      state, state_n;
    logic [FW-1:0]    fail_cnt, fail_n;
    logic [LW-1:0]    lock_cnt, lock_n;
    logic [IW-1:0]    idle_cnt, idle_n;
    logic [USR_W-1:0] sess_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            fail_cnt <= '0;
            lock_cnt <= '0;
            idle_cnt <= '0;
            sess_id  <= '0;
        end else begin
            state    <= state_n;
            fail_cnt <= fail_n;
            lock_cnt <= lock_n;
            idle_cnt <= idle_n;
            sess_id  <= sess_n;
        end
    end

    always_comb begin
        state_n = state;
        fail_n  = fail_cnt;
        lock_n  = lock_cnt;
        idle_n  = idle_cnt;
        sess_n  = sess_id;
        case (state)
            IDLE: begin
                if (grant_req) begin
                    if (usr_id == GRANT_ID) begin
                        state_n = GRANTED;
                        sess_n  = usr_id;
                        fail_n  = '0;
                        idle_n  = '0;
                    end else if (fail_cnt >= FAIL_LAST) begin
                        state_n = LOCKOUT;
                        lock_n  = LOCK_INIT;
                        fail_n  = '0;
                    end else begin
                        fail_n = fail_cnt + 1'b1;
                    end
                end
            end
            GRANTED: begin
                // Release and a foreign user both outrank traffic and grant_req.
                if (grant_rel || (usr_id != sess_id)) begin
                    state_n = IDLE;
                end else if (access) begin
                    idle_n = '0;
                end else if (idle_cnt >= IDLE_LAST) begin
                    state_n = IDLE;
                    idle_n  = '0;
                end else begin
                    idle_n = idle_cnt + 1'b1;
                end
            end
            LOCKOUT: begin
                if (lock_cnt <= LW'(1)) begin
                    state_n = IDLE;
                    lock_n  = '0;
                end else begin
                    lock_n = lock_cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign granted = (state == GRANTED);
    assign locked  = (state == LOCKOUT);

endmodule

// File: rtl/user_grant_access_bank.sv
// rtl/user_grant_access_bank.sv - access-controlled register bank; READ_PROTECT_EN restricts reads to the session holder
module user_grant_access_bank
    import user_grant_pkg::*;
#(
    parameter int               DATA_W       = 8,
    parameter int               USR_W        = 3,
    parameter int               NUM_REGS     = 4,
    parameter logic [USR_W-1:0] GRANT_ID     = USR_W'(DEFAULT_GRANT_ID),
    parameter int               MAX_FAIL     = 3,
    parameter int               LOCK_CYCLES  = 16,
    parameter int               SESS_TIMEOUT = 64
) (
    input logic                     clk,
    input logic                     rst,
    user_grant_access_bank_if.slave bus
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              wr_ack;
    logic              wr_err;
    logic              granted;
    logic              locked;
    logic [USR_W-1:0]  sess_id;
    logic              owner;
    logic              wr_ok;

    ugab_grant_fsm #(
        .USR_W        (USR_W),
        .GRANT_ID     (GRANT_ID),
        .MAX_FAIL     (MAX_FAIL),
        .LOCK_CYCLES  (LOCK_CYCLES),
        .SESS_TIMEOUT (SESS_TIMEOUT)
    ) u_fsm (
        .clk       (clk),
        .rst       (rst),
        .usr_id    (bus.usr_id),
        .grant_req (bus.grant_req),
        .grant_rel (bus.grant_rel),
        .access    (bus.wr_en | bus.rd_en),
        .granted   (granted),
        .locked    (locked),
        .sess_id   (sess_id)
    );

    // A user swap revokes the session in the same cycle, so its write is refused.
    assign owner = granted && (bus.usr_id == sess_id);
    assign wr_ok = bus.wr_en && owner;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[bus.addr] <= bus.data_in;
        end
    end

`ifdef READ_PROTECT_EN
    logic rd_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_err <= 1'b0;
        else     rd_err <= bus.rd_en && !owner;
    end

    assign bus.rd_err = rd_err;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
            rd_valid <= 1'b0;
            wr_ack   <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            rd_valid <= bus.rd_en;
            wr_ack   <= wr_ok;
            wr_err   <= bus.wr_en && !wr_ok;
            if (bus.rd_en) begin
`ifdef READ_PROTECT_EN
                data_out <= owner ? regs[bus.addr] : '0;
`else
                data_out <= regs[bus.addr];
`endif
            end
        end
    end

    assign bus.data_out = data_out;
    assign bus.rd_valid = rd_valid;
    assign bus.wr_ack   = wr_ack;
    assign bus.wr_err   = wr_err;
    assign bus.granted  = granted;
    assign bus.locked   = locked;

endmodule

// File: tb/tb_user_grant_access_bank.sv
// tb/tb_user_grant_access_bank.sv - directed plus randomized bench against a behavioural session model
module tb_user_grant_access_bank;

    localparam int MAX_FAIL     = 3;
    localparam int LOCK_CYCLES  = 16;
    localparam int SESS_TIMEOUT = 64;
    localparam logic [2:0] GID  = 3'b100;
`ifdef READ_PROTECT_EN
    localparam bit PROTECT = 1'b1;
`else
    localparam bit PROTECT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    user_grant_access_bank_if #(.DATA_W(8), .USR_W(3), .NUM_REGS(4)) bus ();

    user_grant_access_bank dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference: mode 0 = no session, 1 = session open, 2 = locked out.
    int         m_mode, m_fail, m_lock, m_idle;
    logic [2:0] m_sess;
    logic [7:0] m_regs [4];
    logic [7:0] e_data;
    logic       e_rd_valid, e_wr_ack, e_wr_err, e_rd_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_fail = 0; m_lock = 0; m_idle = 0; m_sess = '0;
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
        e_data = '0; e_rd_valid = 0; e_wr_ack = 0; e_wr_err = 0; e_rd_err = 0;
    endtask

    task automatic model_clock();
        bit own;
        own        = (m_mode == 1) && (bus.usr_id == m_sess);
        e_wr_ack   = bus.wr_en && own;
        e_wr_err   = bus.wr_en && !own;
        e_rd_valid = bus.rd_en;
        e_rd_err   = 1'b0;
        if (bus.rd_en) begin
            if (PROTECT && !own) begin
                e_data   = '0;
                e_rd_err = 1'b1;
            end else begin
                e_data = m_regs[bus.addr];
            end
        end
        if (e_wr_ack) m_regs[bus.addr] = bus.data_in;
        case (m_mode)
            0: if (bus.grant_req) begin
                if (bus.usr_id == GID) begin
                    m_mode = 1; m_sess = bus.usr_id; m_fail = 0; m_idle = 0;
                end else begin
                    m_fail++;
                    if (m_fail == MAX_FAIL) begin
                        m_mode = 2; m_lock = LOCK_CYCLES; m_fail = 0;
                    end
                end
            end
            1: if (bus.grant_rel || bus.usr_id != m_sess) m_mode = 0;
               else if (bus.rd_en || bus.wr_en) m_idle = 0;
               else begin
                   m_idle++;
                   if (m_idle == SESS_TIMEOUT) m_mode = 0;
               end
            default: begin
                m_lock--;
                if (m_lock == 0) m_mode = 0;
            end
        endcase
    endtask

    task automatic check_outputs(input string pfx);
        chk({pfx, ".granted"},  bus.granted,  m_mode == 1);
        chk({pfx, ".locked"},   bus.locked,   m_mode == 2);
        chk({pfx, ".rd_valid"}, bus.rd_valid, e_rd_valid);
        chk({pfx, ".wr_ack"},   bus.wr_ack,   e_wr_ack);
        chk({pfx, ".wr_err"},   bus.wr_err,   e_wr_err);
        chk({pfx, ".data_out"}, bus.data_out, e_data);
`ifdef READ_PROTECT_EN
        chk({pfx, ".rd_err"},   bus.rd_err,   e_rd_err);
`endif
    endtask

    task automatic step(input string pfx);
        @(posedge clk);
        if (rst) model_reset();
        else     model_clock();
        #1;
        check_outputs(pfx);
    endtask

    task automatic drive(input logic [2:0] usr, input logic greq, input logic grel,
                         input logic wr, input logic rd, input logic [1:0] a, input logic [7:0] d);
        bus.usr_id = usr; bus.grant_req = greq; bus.grant_rel = grel;
        bus.wr_en = wr; bus.rd_en = rd; bus.addr = a; bus.data_in = d;
    endtask

    int lock_len;

    initial begin
        model_reset();
        drive(3'd0, 0, 0, 0, 0, 2'd0, 8'h00);

        step("reset");
        rst = 1'b0;

        drive(3'd0, 0, 0, 0, 1, 2'd2, 8'h00);
        step("rd_after_reset");
        chk("rd_after_reset.const_valid", bus.rd_valid, 1'b1);
        chk("rd_after_reset.const_data", bus.data_out, 8'h00);

        drive(3'd4, 1, 0, 0, 0, 2'd0, 8'h00);
        step("grant");
        chk("grant.const", bus.granted, 1'b1);
        drive(3'd4, 0, 0, 1, 0, 2'd1, 8'h11);
        step("wr11");
        chk("wr11.const_ack", bus.wr_ack, 1'b1);
        drive(3'd4, 0, 0, 0, 1, 2'd1, 8'h00);
        step("rd11");
        chk("rd11.const", bus.data_out, 8'h11);

        drive(3'd4, 0, 1, 0, 0, 2'd0, 8'h00);
        step("release");
        drive(3'd5, 0, 0, 1, 0, 2'd1, 8'h22);
        step("wr22_nogrant");
        chk("wr22_nogrant.const_err", bus.wr_err, 1'b1);
        drive(3'd4, 0, 0, 0, 1, 2'd1, 8'h00);
        step("rd_after_reject");
`ifndef READ_PROTECT_EN
        chk("rd_after_reject.const", bus.data_out, 8'h11);
`endif

        for (int i = 0; i < MAX_FAIL; i++) begin
            drive(3'd5, 1, 0, 0, 0, 2'd0, 8'h00);
            step("bad_grant");
        end
        chk("lockout.const", bus.locked, 1'b1);
        lock_len = 1;
        for (int i = 0; i < 40; i++) begin
            drive(3'd4, 1, 0, 0, 0, 2'd0, 8'h00);
            step("in_lockout");
            chk("in_lockout.granted_const", bus.granted, 1'b0);
            if (!bus.locked) break;
            lock_len++;
        end
        chk("lockout_length", lock_len, LOCK_CYCLES);
        drive(3'd4, 1, 0, 0, 0, 2'd0, 8'h00);
        step("grant_after_lock");
        chk("grant_after_lock.const", bus.granted, 1'b1);

        drive(3'd5, 0, 0, 1, 0, 2'd1, 8'h33);
        step("revoke_wr33");
        chk("revoke_wr33.const_err", bus.wr_err, 1'b1);
        chk("revoke_wr33.const_granted", bus.granted, 1'b0);
        drive(3'd4, 0, 0, 0, 1, 2'd1, 8'h00);
        step("rd_after_revoke");
`ifndef READ_PROTECT_EN
        chk("rd_after_revoke.const", bus.data_out, 8'h11);
`endif

        drive(3'd4, 1, 0, 0, 0, 2'd0, 8'h00);
        step("grant_idle");
        drive(3'd4, 0, 0, 0, 0, 2'd0, 8'h00);
        for (int i = 0; i < SESS_TIMEOUT - 1; i++) step("idle");
        chk("idle63.const", bus.granted, 1'b1);
        step("idle_last");
        chk("idle64.const", bus.granted, 1'b0);
        drive(3'd4, 0, 0, 0, 1, 2'd1, 8'h00);
        step("rd_after_timeout");
`ifdef READ_PROTECT_EN
        chk("rd_after_timeout.const_data", bus.data_out, 8'h00);
        chk("rd_after_timeout.const_err", bus.rd_err, 1'b1);
`else
        chk("rd_after_timeout.const_data", bus.data_out, 8'h11);
`endif

        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 3) != 0) ? 3'd4 : 3'($urandom_range(0, 7)),
                  $urandom_range(0, 5) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                  2'($urandom_range(0, 3)), 8'($urandom));
            step("rand");
            if (i == 300) begin
                rst = 1'b1;
                #1;
                chk("async_rst.granted",  bus.granted,  1'b0);
                chk("async_rst.locked",   bus.locked,   1'b0);
                chk("async_rst.rd_valid", bus.rd_valid, 1'b0);
                chk("async_rst.data_out", bus.data_out, 8'h00);
                model_reset();
                step("in_rst");
                rst = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
